// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM controller.
// Widths here are only defaults; instances override them through parameters.
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 81;
    localparam int RESP_DEPTH = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_st_e;

    // A read may only issue if its data is guaranteed a FIFO slot, counting
    // what is buffered, what is in the macro pipeline, and what leaves now.
    function automatic logic rd_has_room(input logic [1:0] count,
                                         input logic       inflight,
                                         input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(RESP_DEPTH);
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry in-order read-response buffer with valid/ready output and an
// occupancy count used by the controller for read admission.
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [RESP_DEPTH];
    logic              wptr;
    logic              rptr;
    logic              pop;

    assign valid = (count != 2'd0);
    assign pop   = valid && ready;
    assign data  = mem[rptr];

    // Pointers and occupancy; a simultaneous push and pop keeps count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; stale entries are never exposed.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= push_data;
    end

    // The admission rule upstream must never let a push hit a full buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && !pop && count == 2'(RESP_DEPTH)))
                else $error("response fifo overflow");
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for a single-port RW SRAM macro with a 1-cycle
// registered read. Round-robin arbitrates a read and a write channel onto
// the port and buffers read data behind a 2-entry response FIFO.
// Optional build macro SRAM_CTRL_INIT_EN: zero the whole macro after reset
// before accepting any request.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

    gnt_e              gnt;
    logic              last_wr;
    logic              inflight;
    logic              pop;
    logic              rd_elig;
    logic              wr_elig;
    logic              in_init;
    logic [1:0]        fifo_count;
    logic [ADDR_W-1:0] init_addr;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

`ifdef SRAM_CTRL_INIT_EN
    init_st_e init_st;

    // Walk every address once after reset; leave INIT after the last one.
    always_ff @(posedge clock) begin
        if (reset) begin
            init_st   <= ST_INIT;
            init_addr <= '0;
        end else if (init_st == ST_INIT) begin
            init_addr <= init_addr + ADDR_W'(1);
            if (init_addr == '1) init_st <= ST_RUN;
        end
    end

    assign in_init   = (init_st == ST_INIT) && !reset;
    assign init_done = (init_st == ST_RUN);
`else
    assign init_addr = '0;
    assign in_init   = 1'b0;
    assign init_done = 1'b1;
`endif

    sram_resp_fifo #(.DATA_W(DATA_W)) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (sram_rdata),
        .valid     (resp_valid),
        .ready     (resp_ready),
        .data      (resp_data),
        .count     (fifo_count)
    );

    assign pop = resp_valid && resp_ready;

    // Eligibility and round-robin grant; a tie goes to the channel that
    // lost last time. Nothing is granted while reset is asserted.
    always_comb begin
        rd_elig = !reset && init_done && rd_has_room(fifo_count, inflight, pop);
        wr_elig = !reset && init_done;
        gnt     = GNT_NONE;
        if (rd_valid && rd_elig && wr_valid && wr_elig)
            gnt = last_wr ? GNT_RD : GNT_WR;
        else if (rd_valid && rd_elig)
            gnt = GNT_RD;
        else if (wr_valid && wr_elig)
            gnt = GNT_WR;
    end

    assign rd_ready = (gnt == GNT_RD);
    assign wr_ready = (gnt == GNT_WR);

    // Macro pins follow the grant; idle cycles replay the last address and
    // data so the wide buses do not toggle.
    always_comb begin
        sram_en    = in_init || (gnt != GNT_NONE);
        sram_wmode = in_init || (gnt == GNT_WR);
        sram_addr  = hold_addr;
        sram_wdata = hold_wdata;
        if (in_init) begin
            sram_addr  = init_addr;
            sram_wdata = '0;
        end else begin
            case (gnt)
                GNT_RD: sram_addr = rd_addr;
                GNT_WR: begin
                    sram_addr  = wr_addr;
                    sram_wdata = wr_data;
                end
                default: ;
            endcase
        end
    end

    // Read pipeline flag, round-robin history and the idle-hold registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight   <= 1'b0;
            last_wr    <= 1'b1;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            inflight <= (gnt == GNT_RD);
            if (gnt == GNT_RD)      last_wr <= 1'b0;
            else if (gnt == GNT_WR) last_wr <= 1'b1;
            if (sram_en) begin
                hold_addr  <= sram_addr;
                hold_wdata <= sram_wdata;
            end
        end
    end

    // Only one channel may ever see ready in a cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(rd_ready && wr_ready)) else $error("double grant");
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl: behavioural macro, array-based
// reference memory and a queue of expected read responses.
module tb_sram_port_ctrl;
    import sram_ctrl_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int DW    = DEF_DATA_W;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          rd_valid, rd_ready, wr_valid, wr_ready;
    logic [AW-1:0] rd_addr, wr_addr, sram_addr;
    logic [DW-1:0] wr_data, resp_data, sram_wdata, sram_rdata;
    logic          resp_valid, resp_ready, sram_en, sram_wmode, init_done;

    int ncmp = 0;
    int nfail = 0;

    sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .init_done(init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural single-port macro with registered read.
    logic [DW-1:0] macro_mem [DEPTH];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) macro_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= macro_mem[sram_addr];
        end
    end

    // Reference model: memory image, outstanding reads (value + accept cycle).
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_data_q[$];
    int            exp_acc_q[$];
    int            cyc = 0;
    int            icnt = 0;
    bit            last_wr_m = 1'b1;
    bit            s_reset = 1'b1, s_wr, s_rd, s_pop;
    logic [AW-1:0] s_wa, s_ra;
    logic [DW-1:0] s_wd;

    always @(negedge clock) begin
        s_reset = reset;
        s_wr    = wr_valid && wr_ready;
        s_rd    = rd_valid && rd_ready;
        s_pop   = resp_valid && resp_ready;
        s_wa    = wr_addr;
        s_wd    = wr_data;
        s_ra    = rd_addr;
    end

    always @(posedge clock) begin
        if (s_reset) begin
            exp_data_q.delete();
            exp_acc_q.delete();
            last_wr_m = 1'b1;
            icnt      = 0;
        end else begin
            if (s_pop && exp_data_q.size() > 0) begin
                void'(exp_data_q.pop_front());
                void'(exp_acc_q.pop_front());
            end
            if (s_wr) begin
                ref_mem[s_wa] = s_wd;
                last_wr_m     = 1'b1;
            end
            if (s_rd) begin
                exp_data_q.push_back(ref_mem[s_ra]);
                exp_acc_q.push_back(cyc);
                last_wr_m = 1'b0;
            end
            if (icnt < DEPTH) begin
                icnt++;
`ifdef SRAM_CTRL_INIT_EN
                if (icnt == DEPTH)
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
            end
        end
        cyc++;
    end

    function automatic bit m_init_done();
`ifdef SRAM_CTRL_INIT_EN
        return icnt >= DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    // Head of the response queue becomes visible two cycles after acceptance.
    function automatic bit m_resp_valid();
        return exp_acc_q.size() > 0 && cyc >= exp_acc_q[0] + 2;
    endfunction

    function automatic logic [DW-1:0] m_head();
        return (exp_data_q.size() > 0) ? exp_data_q[0] : 'x;
    endfunction

    function automatic void m_ready(output bit er, output bit ew);
        bit pop, rel, wel;
        pop = m_resp_valid() && (resp_ready === 1'b1);
        rel = !reset && m_init_done() && (exp_data_q.size() - int'(pop)) < RESP_DEPTH;
        wel = !reset && m_init_done();
        if (rd_valid && rel && wr_valid && wel) begin
            er = last_wr_m;
            ew = !last_wr_m;
        end else begin
            er = rd_valid && rel;
            ew = wr_valid && wel;
        end
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        rd_valid = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_valid = 1'b1; wr_valid = 1'b0; resp_ready = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        @(negedge clock);
        ncmp++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        ncmp++; if (sram_en !== 1'b0) begin nfail++; $display("FAIL reset_sram_en got %b exp 0", sram_en); end
        ncmp++; if (rd_ready !== 1'b0) begin nfail++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
        step();
        reset = 1'b0; rd_valid = 1'b0;
        @(negedge clock);
        ncmp++; if (init_done !== m_init_done()) begin nfail++; $display("FAIL reset_init_done got %b exp %b", init_done, m_init_done()); end
        ncmp++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL post_reset_resp_valid got %b exp 0", resp_valid); end
    endtask

`ifdef SRAM_CTRL_INIT_EN
    task automatic test_init();
        rd_valid = 1'b1; rd_addr = AW'(DEPTH - 1); resp_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            @(negedge clock);
            ncmp++; if (init_done !== (i >= DEPTH)) begin nfail++; $display("FAIL init_done cycle %0d got %b exp %b", i, init_done, i >= DEPTH); end
            ncmp++; if (rd_ready !== (i >= DEPTH)) begin nfail++; $display("FAIL init_rd_ready cycle %0d got %b", i, rd_ready); end
            if (i == 5) begin
                ncmp++; if ({sram_en, sram_wmode, sram_addr} !== {2'b11, AW'(5)} || sram_wdata !== '0) begin
                    nfail++; $display("FAIL init_walk got en=%b wm=%b a=%0h", sram_en, sram_wmode, sram_addr);
                end
            end
        end
        step(); rd_valid = 1'b0;
        step();
        @(negedge clock);
        ncmp++; if (resp_valid !== 1'b1 || resp_data !== '0) begin nfail++; $display("FAIL init_read_7f got v=%b d=%0h exp 1/0", resp_valid, resp_data); end
        step();
    endtask
`endif

    task automatic test_fill();
        drive_idle(); resp_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            wr_valid = 1'b1; wr_addr = AW'(a); wr_data = rand_word();
            @(negedge clock);
            ncmp++; if (wr_ready !== 1'b1) begin nfail++; $display("FAIL fill_wr_ready addr %0h got %b exp 1", a, wr_ready); end
            step();
        end
        drive_idle();
        step();
    endtask

    task automatic test_write_then_read();
        logic [DW-1:0] d;
        d = 81'h1_2345_6789_ABCD_EF01;
        resp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 7'h05; wr_data = d;
        @(negedge clock);
        ncmp++; if ({wr_ready, sram_en, sram_wmode, sram_addr} !== {3'b111, 7'h05} || sram_wdata !== d) begin
            nfail++; $display("FAIL wtr_write_pins got rdy=%b en=%b wm=%b a=%0h wd=%0h", wr_ready, sram_en, sram_wmode, sram_addr, sram_wdata);
        end
        step();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 7'h05;
        @(negedge clock);
        ncmp++; if ({rd_ready, sram_en, sram_wmode, sram_addr} !== {3'b110, 7'h05}) begin
            nfail++; $display("FAIL wtr_read_pins got rdy=%b en=%b wm=%b a=%0h", rd_ready, sram_en, sram_wmode, sram_addr);
        end
        step();
        rd_valid = 1'b0;
        @(negedge clock);
        ncmp++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL wtr_early_resp got %b exp 0", resp_valid); end
        ncmp++; if (sram_en !== 1'b0 || sram_addr !== 7'h05 || sram_wdata !== d) begin
            nfail++; $display("FAIL wtr_idle_hold got en=%b a=%0h wd=%0h", sram_en, sram_addr, sram_wdata);
        end
        step();
        @(negedge clock);
        ncmp++; if (resp_valid !== 1'b1 || resp_data !== d) begin nfail++; $display("FAIL wtr_resp got v=%b d=%0h exp 1/%0h", resp_valid, resp_data, d); end
        step();
        step();
    endtask

    task automatic test_contention();
        int nresp = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_valid = (i < 6); wr_valid = (i < 6);
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = rand_word();
            @(negedge clock);
            if (i < 6) begin
                ncmp++; if (wr_ready !== (i % 2 == 0) || rd_ready !== (i % 2 == 1)) begin
                    nfail++; $display("FAIL contention_grant cycle %0d got wr=%b rd=%b", i, wr_ready, rd_ready);
                end
            end
            if (resp_valid && resp_ready) begin
                nresp++;
                ncmp++; if (resp_data !== m_head()) begin nfail++; $display("FAIL contention_data got %0h exp %0h", resp_data, m_head()); end
            end
            step();
        end
        ncmp++; if (nresp != 3) begin nfail++; $display("FAIL contention_resp_count got %0d exp 3", nresp); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int nresp = 0;
        bit er, ew;
        drive_idle();
        for (int c = 0; c < 25; c++) begin
            rd_valid = (k < 4); rd_addr = AW'(k + 1); resp_ready = (c >= 6);
            @(negedge clock);
            m_ready(er, ew);
            ncmp++; if (rd_ready !== er) begin nfail++; $display("FAIL bp_rd_ready cycle %0d got %b exp %b", c, rd_ready, er); end
            if (c >= 2 && c <= 5) begin
                ncmp++; if (rd_ready !== 1'b0 || k != 2) begin nfail++; $display("FAIL bp_stall cycle %0d got rdy=%b acc=%0d exp 0/2", c, rd_ready, k); end
            end
            if (resp_valid && resp_ready) begin
                ncmp++; if (resp_data !== ref_mem[nresp + 1]) begin nfail++; $display("FAIL bp_order resp %0d got %0h exp %0h", nresp, resp_data, ref_mem[nresp + 1]); end
                nresp++;
            end
            if (rd_valid && rd_ready) k++;
            step();
        end
        ncmp++; if (k != 4 || nresp != 4) begin nfail++; $display("FAIL bp_totals got acc=%0d resp=%0d exp 4/4", k, nresp); end
        drive_idle();
    endtask

    task automatic test_streaming();
        logic [AW-1:0] sa [16];
        for (int i = 0; i < 16; i++) sa[i] = AW'($urandom_range(0, DEPTH - 1));
        drive_idle(); resp_ready = 1'b1;
        step(); step();
        for (int i = 0; i < 19; i++) begin
            rd_valid = (i < 16);
            if (i < 16) rd_addr = sa[i];
            @(negedge clock);
            if (i < 16) begin
                ncmp++; if (rd_ready !== 1'b1) begin nfail++; $display("FAIL stream_rd_ready cycle %0d got %b exp 1", i, rd_ready); end
            end
            if (i >= 2 && i < 18) begin
                ncmp++; if (resp_valid !== 1'b1 || resp_data !== ref_mem[sa[i-2]]) begin
                    nfail++; $display("FAIL stream_resp cycle %0d got v=%b d=%0h exp %0h", i, resp_valid, resp_data, ref_mem[sa[i-2]]);
                end
            end
            if (i == 18) begin
                ncmp++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL stream_tail got %b exp 0", resp_valid); end
            end
            step();
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_read();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, DEPTH - 1));
        resp_ready = 1'b1; rd_valid = 1'b1; rd_addr = a;
        @(negedge clock);
        ncmp++; if (rd_ready !== 1'b1) begin nfail++; $display("FAIL rmr_accept got %b exp 1", rd_ready); end
        step();
        rd_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        ncmp++; if (sram_en !== 1'b0) begin nfail++; $display("FAIL rmr_sram_en got %b exp 0", sram_en); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ncmp++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL rmr_ghost_resp cycle %0d got %b exp 0", i, resp_valid); end
            step();
        end
`ifdef SRAM_CTRL_INIT_EN
        repeat (DEPTH) step();
`endif
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clock);
        ncmp++; if (rd_ready !== 1'b1) begin nfail++; $display("FAIL rmr_reaccept got %b exp 1", rd_ready); end
        step();
        rd_valid = 1'b0;
        step();
        @(negedge clock);
        ncmp++; if (resp_valid !== 1'b1 || resp_data !== ref_mem[a]) begin
            nfail++; $display("FAIL rmr_reread got v=%b d=%0h exp 1/%0h", resp_valid, resp_data, ref_mem[a]);
        end
        step();
    endtask

    task automatic test_random();
        bit er, ew;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                rd_valid   = ($urandom_range(0, 99) < 60);
                wr_valid   = ($urandom_range(0, 99) < 50);
                resp_ready = ($urandom_range(0, 99) < 65);
            end else begin
                drive_idle();
                resp_ready = 1'b1;
            end
            rd_addr = AW'($urandom_range(0, 7));
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = rand_word();
            @(negedge clock);
            m_ready(er, ew);
            ncmp++; if (rd_ready !== er) begin nfail++; $display("FAIL rand_rd_ready cycle %0d got %b exp %b", c, rd_ready, er); end
            ncmp++; if (wr_ready !== ew) begin nfail++; $display("FAIL rand_wr_ready cycle %0d got %b exp %b", c, wr_ready, ew); end
            ncmp++; if (resp_valid !== m_resp_valid()) begin nfail++; $display("FAIL rand_resp_valid cycle %0d got %b exp %b", c, resp_valid, m_resp_valid()); end
            if (m_resp_valid()) begin
                ncmp++; if (resp_data !== m_head()) begin nfail++; $display("FAIL rand_resp_data cycle %0d got %0h exp %0h", c, resp_data, m_head()); end
            end
            step();
        end
        ncmp++; if (exp_data_q.size() != 0) begin nfail++; $display("FAIL rand_drain got %0d outstanding exp 0", exp_data_q.size()); end
    endtask

    initial begin
        test_reset();
`ifdef SRAM_CTRL_INIT_EN
        test_init();
`endif
        test_fill();
        test_write_then_read();
        test_contention();
        test_backpressure();
        test_streaming();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
